sm_accum_sequencer: RTL

//  Sequences one shared sign-magnitude adder to accumulate a burst of N terms
//  (products from the IIR tap multipliers) into a single sum. Accepts terms over
//  a valid/ready stream, feeds {accumulator, term} to the external combinational

---
 rtl/sm_accum_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sm_accum_sequencer.sv
// Burst accumulator that time-shares one external sign-magnitude adder.
// Saturates on magnitude wrap and never stores negative zero.
module sm_accum_sequencer #(
  parameter int WIDTH     = 31,
  parameter int MAX_TERMS = 8,
  parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             term_valid,
  output logic             term_ready,
  input  logic [WIDTH:0]   term,
  output logic [WIDTH:0]   add_a,
  output logic [WIDTH:0]   add_b,
  input  logic [WIDTH:0]   add_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_TERMS);
  localparam logic [CNT_W-1:0] ONE_N = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic [WIDTH:0]   fixed_s;
  logic             wrap_s;

  // Like-signed operands whose sum magnitude shrank means the adder wrapped.
  function automatic logic ovf_detect(input logic a_sign, input logic b_sign,
                                      input logic [WIDTH-1:0] a_mag,
                                      input logic [WIDTH-1:0] r_mag);
    return (a_sign == b_sign) && (r_mag < a_mag);
  endfunction

  function automatic logic [WIDTH:0] fix_word(input logic [WIDTH:0] a,
                                              input logic [WIDTH:0] b,
                                              input logic [WIDTH:0] r);
    logic [WIDTH:0] res;
    if (ovf_detect(a[WIDTH], b[WIDTH], a[WIDTH-1:0], r[WIDTH-1:0])) begin
      res = {a[WIDTH], {WIDTH{1'b1}}};
    end else if (r[WIDTH-1:0] == {WIDTH{1'b0}}) begin
      res = {(WIDTH+1){1'b0}};
    end else begin
      res = r;
    end
    return res;
  endfunction

  // Next-state, datapath and adder operand selection.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    ovf_d   = ovf_q;
    add_a   = {(WIDTH+1){1'b0}};
    add_b   = {(WIDTH+1){1'b0}};
    fixed_s = {(WIDTH+1){1'b0}};
    wrap_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d   = (num_terms > MAX_N) ? MAX_N : num_terms;
          acc_d = {(WIDTH+1){1'b0}};
          cnt_d = {CNT_W{1'b0}};
          ovf_d = 1'b0;
          if (n_d == {CNT_W{1'b0}}) begin
            state_d = S_DONE;
            sum_d   = {(WIDTH+1){1'b0}};
          end else begin
            state_d = S_ACCUM;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCUM: begin
        add_a   = acc_q;
        add_b   = term;
        fixed_s = fix_word(add_a, add_b, add_result);
        wrap_s  = ovf_detect(add_a[WIDTH], add_b[WIDTH], add_a[WIDTH-1:0],
                             add_result[WIDTH-1:0]);
        if (term_valid && ready_q) begin
          acc_d = fixed_s;
          cnt_d = cnt_q + ONE_N;
          if (wrap_s) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
          if (cnt_q == (n_q - ONE_N)) begin
            state_d = S_DONE;
            sum_d   = fixed_s;
          end else begin
            state_d = S_ACCUM;
          end
        end else begin
          state_d = S_ACCUM;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_ACCUM);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= {(WIDTH+1){1'b0}};
      sum_q   <= {(WIDTH+1){1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      n_q     <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign term_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sum        = sum_q;
  assign overflow   = ovf_q;

endmodule
